equeue_int_param: RTL and testbench
===================================

# equeue_int_param

Parametrised integer issue queue for the Tomasulo core. Holds up to DEPTH dispatched integer instructions, snoops the common data bus (CDB) to capture pending source operands, and issues the oldest fully-ready entry to the integer ALU under a valid/ready handshake. Sits between dispatch and the integer execution unit. Generalises the single-slot integer queue with configurable depth, tag and data widths, operand wakeup, age-ordered select and flush.

## Interface
- DEPTH, 4: number of entries (≥2).
- DATA_W, 32: operand width.
- TAG_W, 6: ROB/physical tag width.
- OPC_W, 6: opcode/function field width.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-low.
- flush  in  1  branch-mispredict flush; discard all entries.
- dispatch_en  in  1  dispatch request.
- dispatch_ready  out  1  queue can accept this cycle.
- dispatch_opcode  in  OPC_W  operation.
- dispatch_rd_tag  in  TAG_W  destination tag.
- dispatch_rs_data / dispatch_rt_data  in  DATA_W  source values (meaningful when valid).
- dispatch_rs_tag / dispatch_rt_tag  in  TAG_W  producer tags (meaningful when not valid).
- dispatch_rsvalid / dispatch_rtvalid  in  1  source value already available.
- cdb_valid  in  1  CDB broadcast this cycle.
- cdb_tag  in  TAG_W  broadcast tag.
- cdb_data  in  DATA_W  broadcast value.
- issue_valid  out  1  an entry is ready to issue.
- issue_ready  in  1  ALU accepts.
- issue_opcode  out  OPC_W; issue_rs_data, issue_rt_data  out  DATA_W; issue_rd_tag  out  TAG_W.

## Operation
- Entry state: valid, opcode, rd_tag, per operand {ready, tag, data}. Entries kept compacted and age-ordered: slot 0 oldest, occupied slots 0..count-1.
- Accept: dispatch_en && dispatch_ready && !flush. New entry written at slot (count − issued), i.e. directly behind survivors.
- Wakeup: each occupied, non-ready operand with tag == cdb_tag while cdb_valid captures cdb_data and sets ready. Incoming dispatch operand that is not valid but matches a same-cycle CDB broadcast is captured as ready (no lost wakeup).
- Select: issue_valid = any occupied entry with both operands ready; outputs present the lowest-index such entry. Purely combinational from registered state.
- Issue fires when issue_valid && issue_ready; selected entry removed at the edge, entries above shift down one slot. Wakeup applies to shifted entries in the same cycle.
- dispatch_ready = (count < DEPTH), registered-state based; no same-cycle credit from an issuing entry.
- flush: all valid bits and count cleared at the edge; concurrent dispatch and issue are discarded (issue handshake still observed by ALU; ALU drops it on flush).
- Count width $clog2(DEPTH+1); count never exceeds DEPTH or underflows.

## Timing
- Reset (rst==0 at edge): count=0, all entries invalid, dispatch_ready=1, issue_valid=0, issue data outputs 0.
- Dispatch-to-issue minimum latency 1 cycle: entry dispatched with both operands valid at edge N asserts issue_valid in cycle N+1.
- CDB wakeup latency 1 cycle: broadcast in cycle N makes dependent entry issuable in cycle N+1.
- issue outputs hold stable while issue_valid && !issue_ready unless a strictly older entry becomes ready (younger may be preempted by older).
- Simultaneous dispatch+issue at count==DEPTH: not possible (dispatch_ready=0); at count==DEPTH−1: both occur, count unchanged.
- Reset or flush mid-operation overrides all other updates.

## Structure
- Shared package/header: DEPTH/DATA_W/TAG_W/OPC_W defaults, opcode encodings, entry record typedef (valid, opcode, rd_tag, operand record).
- Sub-module iq_operand: one operand slot with tag compare and CDB capture, instantiated 2×DEPTH. Selection and compaction stay in top level.

## Test plan
- Reset then dispatch rs/rt valid (opcode 0x20, rd_tag 5, 3 and 4) with issue_ready=1 -> issue_valid next cycle, rs=3, rt=4, rd_tag=5; count back to 0.
- Dispatch rs waiting on tag 9; CDB tag 9 data 0xDEAD two cycles later -> issue_valid one cycle after broadcast with rs=0xDEAD.
- Dispatch with rt tag 7 in same cycle as CDB tag 7 data 0x55 -> entry ready, issues next cycle with rt=0x55.
- Fill DEPTH=4 with issue_ready=0 -> dispatch_ready=0 after 4th; raise issue_ready -> oldest (slot 0) issues first, dispatch_ready=1 next cycle.
- Entries A (waiting), B (ready): B issues first; then A woken -> A issues; order of remaining entries preserved after compaction.
- 3 entries, assert flush with concurrent dispatch -> next cycle count=0, issue_valid=0, dispatch_ready=1.

Source files
------------

// File: rtl/equeue_int_param_pkg.sv
// Shared defaults, opcode encodings and entry record for the integer issue queue.
// The record types use the default widths and serve as the reference shape of one slot.
package equeue_int_param_pkg;

    localparam int DEPTH_DEF  = 4;
    localparam int DATA_W_DEF = 32;
    localparam int TAG_W_DEF  = 6;
    localparam int OPC_W_DEF  = 6;

    typedef enum logic [OPC_W_DEF-1:0] {
        OPC_ADD = 6'h20,
        OPC_SUB = 6'h22,
        OPC_AND = 6'h24,
        OPC_OR  = 6'h25,
        OPC_SLT = 6'h2A
    } opcode_e;

    typedef struct packed {
        logic                  ready;
        logic [TAG_W_DEF-1:0]  tag;
        logic [DATA_W_DEF-1:0] data;
    } operand_t;

    typedef struct packed {
        logic                 valid;
        logic [OPC_W_DEF-1:0] opcode;
        logic [TAG_W_DEF-1:0] rd_tag;
        operand_t             rs;
        operand_t             rt;
    } entry_t;

endpackage

// File: rtl/equeue_int_param_iq_operand.sv
// One source-operand slot. The top selects what this slot should hold next
// (itself, its upper neighbour, or the dispatch port); CDB capture is applied on the way in.
module equeue_int_param_iq_operand #(
    parameter int TAG_W  = 6,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              src_ready_i,
    input  logic [TAG_W-1:0]  src_tag_i,
    input  logic [DATA_W-1:0] src_data_i,
    input  logic              cdb_valid_i,
    input  logic [TAG_W-1:0]  cdb_tag_i,
    input  logic [DATA_W-1:0] cdb_data_i,
    output logic              ready_o,
    output logic [TAG_W-1:0]  tag_o,
    output logic [DATA_W-1:0] data_o
);
    logic              ready_q, ready_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              hit;

    always_comb begin
        hit     = !src_ready_i && cdb_valid_i && (src_tag_i == cdb_tag_i);
        ready_d = src_ready_i | hit;
        tag_d   = src_tag_i;
        data_d  = hit ? cdb_data_i : src_data_i;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ready_q <= 1'b0;
            tag_q   <= '0;
            data_q  <= '0;
        end else begin
            ready_q <= ready_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
        end
    end

    assign ready_o = ready_q;
    assign tag_o   = tag_q;
    assign data_o  = data_q;

endmodule

// File: rtl/equeue_int_param.sv
// Integer issue queue: compacted, age-ordered entries (slot 0 oldest), CDB wakeup,
// oldest-ready select and shift-down compaction on issue.
module equeue_int_param
    import equeue_int_param_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int TAG_W  = TAG_W_DEF,
    parameter int OPC_W  = OPC_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              dispatch_en,
    output logic              dispatch_ready,
    input  logic [OPC_W-1:0]  dispatch_opcode,
    input  logic [TAG_W-1:0]  dispatch_rd_tag,
    input  logic [DATA_W-1:0] dispatch_rs_data,
    input  logic [DATA_W-1:0] dispatch_rt_data,
    input  logic [TAG_W-1:0]  dispatch_rs_tag,
    input  logic [TAG_W-1:0]  dispatch_rt_tag,
    input  logic              dispatch_rsvalid,
    input  logic              dispatch_rtvalid,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    output logic              issue_valid,
    input  logic              issue_ready,
    output logic [OPC_W-1:0]  issue_opcode,
    output logic [DATA_W-1:0] issue_rs_data,
    output logic [DATA_W-1:0] issue_rt_data,
    output logic [TAG_W-1:0]  issue_rd_tag
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(DEPTH);

    logic [CW-1:0]     count_q, count_d, surv;
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [OPC_W-1:0]  opc_q [DEPTH];
    logic [OPC_W-1:0]  opc_d [DEPTH];
    logic [TAG_W-1:0]  rd_q  [DEPTH];
    logic [TAG_W-1:0]  rd_d  [DEPTH];

    // operand index 0 is rs, 1 is rt
    logic              op_rdy   [2][DEPTH];
    logic [TAG_W-1:0]  op_tag   [2][DEPTH];
    logic [DATA_W-1:0] op_data  [2][DEPTH];
    logic              src_rdy  [2][DEPTH];
    logic [TAG_W-1:0]  src_tag  [2][DEPTH];
    logic [DATA_W-1:0] src_data [2][DEPTH];
    logic              dsp_rdy  [2];
    logic [TAG_W-1:0]  dsp_tag  [2];
    logic [DATA_W-1:0] dsp_data [2];

    logic          found, fire, accept;
    logic [SW-1:0] sel;

    assign dsp_rdy[0]  = dispatch_rsvalid;
    assign dsp_rdy[1]  = dispatch_rtvalid;
    assign dsp_tag[0]  = dispatch_rs_tag;
    assign dsp_tag[1]  = dispatch_rt_tag;
    assign dsp_data[0] = dispatch_rs_data;
    assign dsp_data[1] = dispatch_rt_data;

    for (genvar k = 0; k < 2; k++) begin : g_op
        for (genvar i = 0; i < DEPTH; i++) begin : g_slot
            equeue_int_param_iq_operand #(
                .TAG_W (TAG_W),
                .DATA_W(DATA_W)
            ) u_operand (
                .clk        (clk),
                .rst        (rst),
                .src_ready_i(src_rdy[k][i]),
                .src_tag_i  (src_tag[k][i]),
                .src_data_i (src_data[k][i]),
                .cdb_valid_i(cdb_valid),
                .cdb_tag_i  (cdb_tag),
                .cdb_data_i (cdb_data),
                .ready_o    (op_rdy[k][i]),
                .tag_o      (op_tag[k][i]),
                .data_o     (op_data[k][i])
            );
        end
    end

    // Descending scan so the lowest (oldest) ready slot wins.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (valid_q[i] && op_rdy[0][i] && op_rdy[1][i]) begin
                found = 1'b1;
                sel   = SW'(i);
            end
        end
    end

    assign fire   = found && issue_ready;
    assign accept = dispatch_en && dispatch_ready && !flush;
    assign surv   = count_q - CW'(fire);

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < DEPTH; i++) begin
                src_rdy[k][i]  = op_rdy[k][i];
                src_tag[k][i]  = op_tag[k][i];
                src_data[k][i] = op_data[k][i];
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            opc_d[i] = opc_q[i];
            rd_d[i]  = rd_q[i];
        end
        // close the gap left by the issuing entry
        for (int i = 0; i < DEPTH - 1; i++) begin
            if (fire && SW'(i) >= sel) begin
                opc_d[i] = opc_q[i+1];
                rd_d[i]  = rd_q[i+1];
                for (int k = 0; k < 2; k++) begin
                    src_rdy[k][i]  = op_rdy[k][i+1];
                    src_tag[k][i]  = op_tag[k][i+1];
                    src_data[k][i] = op_data[k][i+1];
                end
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (accept && CW'(i) == surv) begin
                opc_d[i] = dispatch_opcode;
                rd_d[i]  = dispatch_rd_tag;
                for (int k = 0; k < 2; k++) begin
                    src_rdy[k][i]  = dsp_rdy[k];
                    src_tag[k][i]  = dsp_tag[k];
                    src_data[k][i] = dsp_data[k];
                end
            end
        end
        count_d = flush ? '0 : surv + CW'(accept);
        for (int i = 0; i < DEPTH; i++) begin
            valid_d[i] = !flush && (CW'(i) < count_d);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                opc_q[i] <= '0;
                rd_q[i]  <= '0;
            end
        end else begin
            count_q <= count_d;
            valid_q <= valid_d;
            for (int i = 0; i < DEPTH; i++) begin
                opc_q[i] <= opc_d[i];
                rd_q[i]  <= rd_d[i];
            end
        end
    end

    assign dispatch_ready = (count_q < CW'(DEPTH));
    assign issue_valid    = found;
    assign issue_opcode   = found ? opc_q[sel]      : '0;
    assign issue_rd_tag   = found ? rd_q[sel]       : '0;
    assign issue_rs_data  = found ? op_data[0][sel] : '0;
    assign issue_rt_data  = found ? op_data[1][sel] : '0;

endmodule

// File: tb/tb_equeue_int_param.sv
// Scoreboard bench: the driver advances an age-ordered list model and queues expected issues;
// the monitor pops and compares whenever the DUT completes an issue handshake.
module tb_equeue_int_param;
    import equeue_int_param_pkg::*;

    localparam int DEPTH  = DEPTH_DEF;
    localparam int DATA_W = DATA_W_DEF;
    localparam int TAG_W  = TAG_W_DEF;
    localparam int OPC_W  = OPC_W_DEF;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              flush = 1'b0;
    logic              dispatch_en = 1'b0;
    logic              dispatch_ready;
    logic [OPC_W-1:0]  dispatch_opcode = '0;
    logic [TAG_W-1:0]  dispatch_rd_tag = '0;
    logic [DATA_W-1:0] dispatch_rs_data = '0;
    logic [DATA_W-1:0] dispatch_rt_data = '0;
    logic [TAG_W-1:0]  dispatch_rs_tag = '0;
    logic [TAG_W-1:0]  dispatch_rt_tag = '0;
    logic              dispatch_rsvalid = 1'b0;
    logic              dispatch_rtvalid = 1'b0;
    logic              cdb_valid = 1'b0;
    logic [TAG_W-1:0]  cdb_tag = '0;
    logic [DATA_W-1:0] cdb_data = '0;
    logic              issue_valid;
    logic              issue_ready = 1'b0;
    logic [OPC_W-1:0]  issue_opcode;
    logic [DATA_W-1:0] issue_rs_data;
    logic [DATA_W-1:0] issue_rt_data;
    logic [TAG_W-1:0]  issue_rd_tag;

    entry_t model[$];
    entry_t exp_q[$];
    logic   exp_iv, exp_dr;
    bit     chk_en = 1'b0;
    int     tests = 0;
    int     fails = 0;

    equeue_int_param dut (
        .clk             (clk),
        .rst             (rst),
        .flush           (flush),
        .dispatch_en     (dispatch_en),
        .dispatch_ready  (dispatch_ready),
        .dispatch_opcode (dispatch_opcode),
        .dispatch_rd_tag (dispatch_rd_tag),
        .dispatch_rs_data(dispatch_rs_data),
        .dispatch_rt_data(dispatch_rt_data),
        .dispatch_rs_tag (dispatch_rs_tag),
        .dispatch_rt_tag (dispatch_rt_tag),
        .dispatch_rsvalid(dispatch_rsvalid),
        .dispatch_rtvalid(dispatch_rtvalid),
        .cdb_valid       (cdb_valid),
        .cdb_tag         (cdb_tag),
        .cdb_data        (cdb_data),
        .issue_valid     (issue_valid),
        .issue_ready     (issue_ready),
        .issue_opcode    (issue_opcode),
        .issue_rs_data   (issue_rs_data),
        .issue_rt_data   (issue_rt_data),
        .issue_rd_tag    (issue_rd_tag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic operand_t wake(input operand_t o);
        operand_t r;
        r = o;
        if (!r.ready && cdb_valid && r.tag == cdb_tag) begin
            r.ready = 1'b1;
            r.data  = cdb_data;
        end
        return r;
    endfunction

    // One cycle of the reference: oldest ready entry leaves on handshake, survivors are
    // woken by the CDB, an accepted dispatch joins the tail, and flush empties everything.
    task automatic model_step();
        int       s;
        bit       acc;
        entry_t   ne;
        operand_t o;
        s = -1;
        for (int i = 0; i < model.size(); i++) begin
            if (model[i].rs.ready && model[i].rt.ready) begin
                s = i;
                break;
            end
        end
        exp_iv = (s >= 0);
        exp_dr = (model.size() < DEPTH);
        acc    = dispatch_en && exp_dr && !flush;
        if (s >= 0 && issue_ready) begin
            exp_q.push_back(model[s]);
            model.delete(s);
        end
        for (int i = 0; i < model.size(); i++) begin
            model[i].rs = wake(model[i].rs);
            model[i].rt = wake(model[i].rt);
        end
        if (acc) begin
            ne.valid  = 1'b1;
            ne.opcode = dispatch_opcode;
            ne.rd_tag = dispatch_rd_tag;
            o.ready = dispatch_rsvalid; o.tag = dispatch_rs_tag; o.data = dispatch_rs_data;
            ne.rs = wake(o);
            o.ready = dispatch_rtvalid; o.tag = dispatch_rt_tag; o.data = dispatch_rt_data;
            ne.rt = wake(o);
            model.push_back(ne);
        end
        if (flush) model.delete();
    endtask

    always @(negedge clk) begin
        entry_t e;
        #1;
        if (chk_en) begin
            chk("issue_valid", 64'(issue_valid), 64'(exp_iv));
            chk("dispatch_ready", 64'(dispatch_ready), 64'(exp_dr));
            if (issue_valid && issue_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL issue_unexpected: got rd_tag %0h expected no issue at %0t",
                             issue_rd_tag, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("issue_opcode", 64'(issue_opcode), 64'(e.opcode));
                    chk("issue_rd_tag", 64'(issue_rd_tag), 64'(e.rd_tag));
                    chk("issue_rs_data", 64'(issue_rs_data), 64'(e.rs.data));
                    chk("issue_rt_data", 64'(issue_rt_data), 64'(e.rt.data));
                end
            end
        end
    end

    task automatic idle();
        dispatch_en = 1'b0;
        cdb_valid   = 1'b0;
        flush       = 1'b0;
        issue_ready = 1'b1;
    endtask

    task automatic disp(input logic [OPC_W-1:0] opc, input logic [TAG_W-1:0] rd,
                        input logic rsv, input logic [TAG_W-1:0] rst_t, input logic [DATA_W-1:0] rsd,
                        input logic rtv, input logic [TAG_W-1:0] rtt, input logic [DATA_W-1:0] rtd);
        dispatch_en      = 1'b1;
        dispatch_opcode  = opc;
        dispatch_rd_tag  = rd;
        dispatch_rsvalid = rsv;
        dispatch_rs_tag  = rst_t;
        dispatch_rs_data = rsd;
        dispatch_rtvalid = rtv;
        dispatch_rt_tag  = rtt;
        dispatch_rt_data = rtd;
    endtask

    task automatic cdb(input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d);
        cdb_valid = 1'b1;
        cdb_tag   = t;
        cdb_data  = d;
    endtask

    task automatic step();
        model_step();
        @(negedge clk);
        idle();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_issue_valid"}, 64'(issue_valid), 64'(0));
        chk({tag, "_dispatch_ready"}, 64'(dispatch_ready), 64'(1));
        chk({tag, "_issue_rs_data"}, 64'(issue_rs_data), 64'(0));
        chk({tag, "_issue_rt_data"}, 64'(issue_rt_data), 64'(0));
        chk({tag, "_issue_opcode"}, 64'(issue_opcode), 64'(0));
        chk({tag, "_issue_rd_tag"}, 64'(issue_rd_tag), 64'(0));
    endtask

    initial begin
        rst = 1'b0;
        disp(6'h20, 6'd1, 1'b1, 6'd0, 32'h1, 1'b1, 6'd0, 32'h2);
        issue_ready = 1'b1;
        repeat (2) @(negedge clk);
        #2;
        check_reset_outputs("reset");
        rst = 1'b1;
        idle();
        chk_en = 1'b1;

        // both operands ready: issues the following cycle
        disp(6'h20, 6'd5, 1'b1, 6'd0, 32'd3, 1'b1, 6'd0, 32'd4);
        step();
        step();
        step();

        // rs waits on tag 9, broadcast two cycles after dispatch
        disp(OPC_SUB, 6'd10, 1'b0, 6'd9, 32'h0, 1'b1, 6'd0, 32'h11);
        step();
        step();
        cdb(6'd9, 32'hDEAD);
        step();
        step();
        step();

        // rt tag 7 broadcast in the dispatch cycle itself
        disp(OPC_AND, 6'd12, 1'b1, 6'd0, 32'h77, 1'b0, 6'd7, 32'h0);
        cdb(6'd7, 32'h55);
        step();
        step();
        step();

        // fill to DEPTH, try one more while full, then drain with a dispatch at DEPTH-1
        for (int i = 0; i < DEPTH; i++) begin
            issue_ready = 1'b0;
            disp(OPC_OR, 6'(20 + i), 1'b1, 6'd0, 32'(100 + i), 1'b1, 6'd0, 32'(200 + i));
            step();
        end
        issue_ready = 1'b0;
        disp(OPC_OR, 6'd30, 1'b1, 6'd0, 32'hBAD, 1'b1, 6'd0, 32'hBAD);
        step();
        step();
        disp(OPC_SLT, 6'd31, 1'b1, 6'd0, 32'h31, 1'b1, 6'd0, 32'h32);
        step();
        repeat (DEPTH + 1) step();

        // older waiting entry A, younger ready B and C: B, C first, then A after wakeup
        issue_ready = 1'b0;
        disp(OPC_ADD, 6'd40, 1'b0, 6'd12, 32'h0, 1'b1, 6'd0, 32'hA1);
        step();
        issue_ready = 1'b0;
        disp(OPC_SUB, 6'd41, 1'b1, 6'd0, 32'hB0, 1'b1, 6'd0, 32'hB1);
        step();
        issue_ready = 1'b0;
        disp(OPC_AND, 6'd42, 1'b1, 6'd0, 32'hC0, 1'b1, 6'd0, 32'hC1);
        step();
        step();
        step();
        step();
        cdb(6'd12, 32'hA0);
        step();
        step();
        step();

        // three entries, then flush alongside a dispatch
        for (int i = 0; i < 3; i++) begin
            issue_ready = 1'b0;
            disp(OPC_ADD, 6'(50 + i), 1'b1, 6'd0, 32'(i), 1'b1, 6'd0, 32'(i));
            step();
        end
        issue_ready = 1'b0;
        flush = 1'b1;
        disp(OPC_ADD, 6'd60, 1'b1, 6'd0, 32'h60, 1'b1, 6'd0, 32'h61);
        step();
        step();

        for (int n = 0; n < 3000; n++) begin
            dispatch_en      = ($urandom_range(0, 9) < 6);
            dispatch_opcode  = OPC_W'($urandom);
            dispatch_rd_tag  = TAG_W'($urandom);
            dispatch_rsvalid = 1'($urandom_range(0, 1));
            dispatch_rs_tag  = TAG_W'($urandom_range(0, 7));
            dispatch_rs_data = $urandom;
            dispatch_rtvalid = 1'($urandom_range(0, 1));
            dispatch_rt_tag  = TAG_W'($urandom_range(0, 7));
            dispatch_rt_data = $urandom;
            cdb_valid        = ($urandom_range(0, 2) != 0);
            cdb_tag          = TAG_W'($urandom_range(0, 7));
            cdb_data         = $urandom;
            issue_ready      = ($urandom_range(0, 9) < 7);
            flush            = ($urandom_range(0, 39) == 0);
            step();
        end

        // load the queue, then reset with a dispatch pending: reset must win
        for (int i = 0; i < 3; i++) begin
            issue_ready = 1'b0;
            disp(OPC_OR, 6'(i), 1'b1, 6'd0, 32'(i), 1'b1, 6'd0, 32'(i));
            step();
        end
        chk("exp_queue_drained", 64'(exp_q.size()), 64'(0));
        chk_en = 1'b0;
        rst = 1'b0;
        disp(OPC_OR, 6'd9, 1'b1, 6'd0, 32'h9, 1'b1, 6'd0, 32'h9);
        model.delete();
        @(negedge clk);
        #2;
        check_reset_outputs("midrun_reset");
        rst = 1'b1;
        idle();
        chk_en = 1'b1;
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
